// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-byte register file behind an auto-incrementing pointer.
// Optional feature: define I2C_TARGET_GLITCH_FILTER_EN for a 3-sample majority filter on SDA/SCL.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sda_in,
  input  logic        scl_in,
  output logic        sda_oe,
  output logic        scl_oe,
  output logic [63:0] regs_q,
  output logic        wr_stb,
  output logic [2:0]  wr_idx,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      sda_sync, scl_sync;
  logic            sda_f, scl_f, sda_p, scl_p;
  logic            start_ev, stop_ev, scl_rise, scl_fall;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shreg, shreg_nxt, shift_in;
  logic [2:0]      ptr, ptr_nxt, ptr_inc, bit_sel;
  logic [7:0][7:0] regs, regs_nxt;
  logic            sda_oe_nxt, busy_nxt, wr_stb_nxt;
  logic [2:0]      wr_idx_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_sync <= '1;
      scl_sync <= '1;
    end else begin
      sda_sync <= {sda_sync[0], sda_in};
      scl_sync <= {scl_sync[0], scl_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] sda_hist, scl_hist;
  logic       sda_maj, scl_maj;

  // Majority of the current and two previous samples: a 1-clk pulse never wins the vote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_hist <= '1;
      scl_hist <= '1;
      sda_maj  <= 1'b1;
      scl_maj  <= 1'b1;
    end else begin
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_maj  <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[1]);
      scl_maj  <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[1]);
    end
  end

  assign sda_f = sda_maj;
  assign scl_f = scl_maj;
`else
  assign sda_f = sda_sync[1];
  assign scl_f = scl_sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_p <= 1'b1;
      scl_p <= 1'b1;
    end else begin
      sda_p <= sda_f;
      scl_p <= scl_f;
    end
  end

  assign start_ev = scl_p & scl_f & sda_p & ~sda_f;
  assign stop_ev  = scl_p & scl_f & ~sda_p & sda_f;
  assign scl_rise = ~scl_p & scl_f;
  assign scl_fall = scl_p & ~scl_f;
  assign shift_in = {shreg[6:0], sda_f};
  assign ptr_inc  = ptr + 3'd1;
  assign bit_sel  = 3'd7 - bit_cnt[2:0];
  assign regs_q   = regs;
  assign scl_oe   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      regs    <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      regs    <= regs_nxt;
      sda_oe  <= sda_oe_nxt;
      busy    <= busy_nxt;
      wr_stb  <= wr_stb_nxt;
      wr_idx  <= wr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    regs_nxt    = regs;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    wr_stb_nxt  = 1'b0;
    wr_idx_nxt  = wr_idx;
    if (stop_ev) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_ev) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == TARGET_ADDR) begin
              state_nxt  = ADDR_ACK;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            // A read starts driving its first bit on the same fall that releases the ACK.
            if (shreg[0]) begin
              state_nxt  = RDATA;
              sda_oe_nxt = ~regs[ptr][7];
            end else begin
              state_nxt  = PTR;
              sda_oe_nxt = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            ptr_nxt    = shreg[2:0];
            sda_oe_nxt = 1'b1;
            state_nxt  = PTR_ACK;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              regs_nxt[ptr] = shift_in;
              wr_stb_nxt    = 1'b1;
              wr_idx_nxt    = ptr;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_nxt = 1'b1;
            state_nxt  = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            ptr_nxt     = ptr_inc;
            bit_cnt_nxt = '0;
            state_nxt   = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = RACK;
            end else begin
              sda_oe_nxt = ~regs[ptr][bit_sel];
            end
          end
        end
        RACK: begin
          // bit_cnt doubles as the "master ACKed" flag while in this state.
          if (scl_rise) begin
            if (sda_f) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end else begin
              bit_cnt_nxt = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            ptr_nxt     = ptr_inc;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = ~regs[ptr_inc][7];
            state_nxt   = RDATA;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bus-master tasks, vector table, random transactions
// against a byte-array model of the register file and pointer.
module tb_i2c_target_regs;

  localparam int HP = 8;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_sda = 1'b1;
  logic        m_scl = 1'b1;
  logic        sda_in, scl_in, sda_oe, scl_oe, wr_stb, busy;
  logic [63:0] regs_q;
  logic [2:0]  wr_idx;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  mreg [8];
  logic [2:0]  mptr;
  logic [7:0]  wbuf [4];
  int          stb_log[$];
  int          oe_cnt = 0;

  assign sda_in = m_sda & ~sda_oe;
  assign scl_in = m_scl & ~scl_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'h21)) dut (
    .clk(clk), .reset(reset), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .regs_q(regs_q),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_stb) stb_log.push_back(int'(wr_idx));
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mreg[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(HP);
    m_scl = 1'b1; tick(HP);
    m_sda = 1'b0; tick(HP);
    m_scl = 1'b0; tick(HP);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(HP);
    m_scl = 1'b1; tick(HP);
    m_sda = 1'b1; tick(HP);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(HP);
    m_scl = 1'b1; tick(HP);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; tick(HP);
    m_scl = 1'b1; tick(HP/2);
    ack = (sda_in == 1'b0);
    tick(HP/2);
    m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(HP);
      m_scl = 1'b1; tick(HP/2);
      b[i] = sda_in;
      tick(HP/2);
      m_scl = 1'b0;
    end
    m_sda = mack ? 1'b0 : 1'b1; tick(HP);
    m_scl = 1'b1; tick(HP);
    m_scl = 1'b0;
  endtask

  task automatic txn_write(input logic [2:0] p, input int n, input string tag);
    int         base;
    logic       ack;
    logic [2:0] idx;
    base = stb_log.size();
    bus_start();
    write_byte(8'h42, ack);
    check({tag, "_addr_ack"}, 64'(ack), 64'(1));
    check({tag, "_busy_mid"}, 64'(busy), 64'(1));
    write_byte({5'b0, p}, ack);
    check({tag, "_ptr_ack"}, 64'(ack), 64'(1));
    for (int k = 0; k < n; k++) begin
      write_byte(wbuf[k], ack);
      check({tag, "_data_ack"}, 64'(ack), 64'(1));
      idx = p + 3'(k);
      mreg[idx] = wbuf[k];
    end
    bus_stop();
    mptr = p + 3'(n);
    check({tag, "_stb_count"}, 64'(stb_log.size() - base), 64'(n));
    for (int k = 0; k < n && base + k < stb_log.size(); k++) begin
      idx = p + 3'(k);
      check({tag, "_wr_idx"}, 64'(stb_log[base + k]), 64'(idx));
    end
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_regs"}, regs_q, model_regs());
  endtask

  task automatic txn_read(input int n, input logic set_ptr, input logic [2:0] p, input string tag);
    logic       ack;
    logic [7:0] b;
    logic [2:0] idx;
    if (set_ptr) begin
      bus_start();
      write_byte(8'h42, ack);
      check({tag, "_waddr_ack"}, 64'(ack), 64'(1));
      write_byte({5'b0, p}, ack);
      check({tag, "_ptr_ack"}, 64'(ack), 64'(1));
      mptr = p;
    end
    bus_start();
    write_byte(8'h43, ack);
    check({tag, "_raddr_ack"}, 64'(ack), 64'(1));
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, b);
      idx = mptr + 3'(k);
      check({tag, "_rd_byte"}, 64'(b), 64'(mreg[idx]));
    end
    check({tag, "_busy_nack"}, 64'(busy), 64'(0));
    bus_stop();
    mptr = mptr + 3'(n - 1);
  endtask

  task automatic txn_wrong(input logic [6:0] a, input logic rw, input string tag);
    logic ack;
    int   oe0;
    oe0 = oe_cnt;
    bus_start();
    write_byte({a, rw}, ack);
    check({tag, "_ack"}, 64'(ack), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    bus_stop();
    check({tag, "_oe_seen"}, 64'(oe_cnt - oe0), 64'(0));
    check({tag, "_regs"}, regs_q, model_regs());
  endtask

  initial begin
    vec_t       tbl [8];
    logic       ack;
    logic [7:0] b;
    logic [6:0] a;
    int         base;
    int         op;

    tbl[0] = '{7'h21, 8'h03, 8'h11, 1'b1, 8'h11};
    tbl[1] = '{7'h21, 8'hFA, 8'hC3, 1'b1, 8'hC3};
    tbl[2] = '{7'h22, 8'h02, 8'h99, 1'b0, 8'hC3};
    tbl[3] = '{7'h21, 8'h07, 8'hFF, 1'b1, 8'hFF};
    tbl[4] = '{7'h10, 8'h07, 8'h00, 1'b0, 8'hFF};
    tbl[5] = '{7'h21, 8'h00, 8'h80, 1'b1, 8'h80};
    tbl[6] = '{7'h20, 8'h00, 8'h55, 1'b0, 8'h80};
    tbl[7] = '{7'h21, 8'h01, 8'h01, 1'b1, 8'h01};
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mptr = 3'd0;

    tick(3);
    check("rst_regs", regs_q, 64'h0);
    check("rst_sda_oe", 64'(sda_oe), 64'(0));
    check("rst_scl_oe", 64'(scl_oe), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_stb", 64'(wr_stb), 64'(0));
    check("rst_wr_idx", 64'(wr_idx), 64'(0));
    reset = 1'b0;
    tick(4);

    for (int i = 0; i < 8; i++) begin
      bus_start();
      write_byte({tbl[i].addr, 1'b0}, ack);
      check($sformatf("tbl%0d_ack", i), 64'(ack), 64'(tbl[i].exp_ack));
      if (ack) begin
        write_byte(tbl[i].ptr_byte, ack);
        write_byte(tbl[i].data, ack);
      end
      bus_stop();
      if (tbl[i].addr == 7'h21) mreg[tbl[i].ptr_byte[2:0]] = tbl[i].data;
      bus_start();
      write_byte(8'h42, ack);
      write_byte(tbl[i].ptr_byte, ack);
      bus_start();
      write_byte(8'h43, ack);
      read_byte(1'b0, b);
      bus_stop();
      mptr = tbl[i].ptr_byte[2:0];
      check($sformatf("tbl%0d_rd", i), 64'(b), 64'(tbl[i].exp_rd));
    end

    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    txn_write(3'd3, 2, "wr_a5_5a");
    check("wr_a5_5a_byte3", 64'(regs_q[31:24]), 64'(8'hA5));
    check("wr_a5_5a_byte4", 64'(regs_q[39:32]), 64'(8'h5A));

    txn_read(2, 1'b1, 3'd7, "rd_wrap");

    txn_wrong(7'h28, 1'b0, "addr_50");

    base = stb_log.size();
    bus_start();
    write_byte(8'h42, ack);
    check("abort_addr_ack", 64'(ack), 64'(1));
    write_byte(8'h05, ack);
    check("abort_ptr_ack", 64'(ack), 64'(1));
    mptr = 3'd5;
    b = 8'hF0;
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    bus_stop();
    check("abort_stb", 64'(stb_log.size() - base), 64'(0));
    check("abort_regs", regs_q, model_regs());
    check("abort_busy", 64'(busy), 64'(0));
    txn_read(1, 1'b0, 3'd0, "abort_ptr_kept");

    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
        txn_write(3'($urandom_range(0, 7)), $urandom_range(1, 4), "rnd_wr");
      end else if (op == 1) begin
        txn_read($urandom_range(1, 4), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd_rd");
      end else begin
        a = 7'($urandom_range(0, 127));
        while (a == 7'h21) a = 7'($urandom_range(0, 127));
        txn_wrong(a, 1'($urandom), "rnd_wrong");
      end
    end

    wbuf[0] = 8'h00;
    txn_write(3'd6, 1, "pre_rst");
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'h06, ack);
    bus_start();
    write_byte(8'h43, ack);
    check("rst_rd_addr_ack", 64'(ack), 64'(1));
    m_sda = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(HP); m_scl = 1'b1; tick(HP); m_scl = 1'b0;
    end
    tick(HP); m_scl = 1'b1; tick(HP/2);
    check("rst_mid_oe_before", 64'(sda_oe), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_sda_oe", 64'(sda_oe), 64'(0));
    check("rst_mid_scl_oe", 64'(scl_oe), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_regs", regs_q, 64'h0);
    check("rst_mid_wr_stb", 64'(wr_stb), 64'(0));
    check("rst_mid_wr_idx", 64'(wr_idx), 64'(0));
    tick(HP);
    reset = 1'b0;
    tick(HP);
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mptr = 3'd0;
    wbuf[0] = 8'h6B; wbuf[1] = 8'h94;
    txn_write(3'd2, 2, "post_rst");
    txn_read(2, 1'b1, 3'd2, "post_rst");

    bus_start();
    write_byte(8'h42, ack);
    check("glitch_addr_ack", 64'(ack), 64'(1));
    write_byte(8'h04, ack);
    check("glitch_ptr_ack", 64'(ack), 64'(1));
    m_sda = 1'b0; tick(HP);
    m_scl = 1'b1; tick(HP/2);
    m_scl = 1'b0; tick(1);
    m_scl = 1'b1; tick(HP/2);
    m_scl = 1'b0;
    b = 8'h3C;
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; tick(HP);
    m_scl = 1'b1; tick(HP/2);
    ack = (sda_in == 1'b0);
    tick(HP/2);
    m_scl = 1'b0;
    bus_stop();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("glitch_data_ack", 64'(ack), 64'(1));
    check("glitch_byte", 64'(regs_q[39:32]), 64'(8'h3C));
`else
    n_vec++;
    if (regs_q[39:32] === 8'h3C) begin
      n_miss++;
      $display("FAIL glitch_unfiltered: got 0x%0h, required a byte other than 0x3c", regs_q[39:32]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h21: 7-bit bus address the block responds to.
REQ-002 SHALL have port clk, input, 1 bit: sole clock. All logic is sampled on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sda_in, input, 1 bit: bus SDA level, asynchronous to clk.
REQ-005 SHALL have port scl_in, input, 1 bit: bus SCL level, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain).
REQ-007 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low. Held 0; the block never stretches the clock.
REQ-008 SHALL have port regs_q, output, 64 bits: register file; byte n = regs_q[8n+7:8n], n=0..7.
REQ-009 SHALL have port wr_stb, output, 1 bit: one-clk pulse when a register byte is written.
REQ-010 SHALL have port wr_idx, output, 3 bits: register index written; valid while wr_stb=1.
REQ-011 SHALL have port busy, output, 1 bit: 1 from an addressed START until the next STOP or NACK.

Function
REQ-012 SHALL pass sda_in and scl_in through 2-flop synchronizers; all decoding uses the synchronized values only.
REQ-013 SHALL detect START as SDA falling while SCL=1, and STOP as SDA rising while SCL=1.
REQ-014 SHALL define SCL rise/fall events as a change of the synchronized SCL between consecutive clks.
REQ-015 SHALL sample data bits on SCL rise, MSB first.
REQ-016 SHALL change sda_oe only on the clk following an SCL fall event.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-018 SHALL transition to ADDR from any state on START, including repeated START, and clear the bit counter.
REQ-019 SHALL transition to IDLE from any state on STOP, release sda_oe and clear busy.
REQ-020 SHALL, in ADDR after 8 bits: if addr==TARGET_ADDR, drive ACK (sda_oe=1) for the 9th bit; otherwise return to IDLE with sda_oe=0.
REQ-021 SHALL, after an ACKed address with R/W=0, go to PTR; the next byte loads the pointer from bits [2:0] (bits [7:3] ignored) and is ACKed.
REQ-022 SHALL, for each subsequent write byte: store it to regs_q[ptr] and pulse wr_stb with wr_idx=ptr on the 8th SCL rise, ACK it, then increment ptr.
REQ-023 SHALL, after an ACKed address with R/W=1, go to RDATA and shift out regs_q[ptr] MSB first, with sda_oe=~bit, starting at the SCL fall that ends the ACK.
REQ-024 SHALL release SDA for the 9th (master ACK) bit and sample it in RACK: ACK(0) increments ptr and sends the next byte; NACK(1) goes to IDLE with busy=0.
REQ-025 SHALL increment ptr modulo 8 (7 wraps to 0) for reads and writes.
REQ-026 SHALL release the ACK (sda_oe=0) on the SCL fall ending the 9th bit.
REQ-027 SHALL retain ptr across transactions until it is rewritten or reset.

Reset
REQ-028 SHALL, on reset assertion, immediately force: sda_oe=0, scl_oe=0, regs_q=0, wr_stb=0, wr_idx=0, busy=0, ptr=0, state=IDLE, synchronizers=1.
REQ-029 SHALL, on reset mid-transfer, release the bus immediately and ignore all bus activity until the next START after reset deasserts.

Configuration
REQ-030 SHALL, when I2C_TARGET_GLITCH_FILTER_EN is defined, add a 3-sample majority filter after each synchronizer, so any pulse shorter than 2 clks is rejected, at 2 extra clks of latency.
REQ-031 SHALL, when I2C_TARGET_GLITCH_FILTER_EN is undefined, use the synchronizer outputs directly, with no filter logic present.

Verification
REQ-032 Write S,0x42(ACK),0x03(ACK),0xA5(ACK),0x5A(ACK),P -> regs_q[31:24]=A5, regs_q[39:32]=5A; two wr_stb pulses, wr_idx=3 then 4; busy low after P.
REQ-033 Ptr write 0x07 then Sr,0x43, read 2 bytes with master ACK then NACK -> SDA carries regs[7] then regs[0] (wrap); busy=0 after NACK.
REQ-034 S,0x50 (wrong address) -> no ACK, sda_oe stays 0, busy=0, regs_q unchanged.
REQ-035 Reset asserted during bit 5 of a read byte -> sda_oe=0 on the same cycle, all outputs at reset values; next valid transaction completes correctly.
REQ-036 STOP issued after 4 bits of a write data byte -> no wr_stb pulse, regs_q unchanged, state=IDLE.
REQ-037 With I2C_TARGET_GLITCH_FILTER_EN defined, inject a 1-clk SCL low glitch mid-bit -> bit count unaffected and byte 0x3C is written correctly; without the macro, the same glitch corrupts the count (documents the feature).
